// File: rtl/reg_cmd_mem_if.sv
// reg_cmd_mem_if: register-style command bus for reg_cmd_mem.
// The master drives the data, address and command registers.
// The slave (the memory block) returns status and read data.
interface reg_cmd_mem_if #(
  parameter int REG_WIDTH = 32
);

  logic [REG_WIDTH-1:0] data_in_register;
  logic [REG_WIDTH-1:0] address_register;
  logic [REG_WIDTH-1:0] cmd_register;
  logic [REG_WIDTH-1:0] status_register;
  logic [REG_WIDTH-1:0] data_o_register;

  modport master (
    output data_in_register,
    output address_register,
    output cmd_register,
    input  status_register,
    input  data_o_register
  );

  modport slave (
    input  data_in_register,
    input  address_register,
    input  cmd_register,
    output status_register,
    output data_o_register
  );

endinterface

// File: rtl/reg_cmd_mem.sv
// reg_cmd_mem: register-driven single-port memory with WRITE, READ and an
// optional multi-word FILL command.
// Optional feature macro: REG_CMD_MEM_FILL_EN enables FILL (code 3). When it
// is undefined, code 3 is treated like any other illegal command and the
// FILL state and word counter are not built.
// address_register[15:0] is the start address, [31:16] is the fill count - 1.
// status_register: bit0 busy, bit1 done, bit2 error, bit3 dropped.
module reg_cmd_mem #(
  parameter int REG_WIDTH  = 32,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024
) (
  input logic          clk,
  input logic          rst,
  reg_cmd_mem_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH17 = 17'(DEPTH);
  localparam logic [16:0] LAST17  = 17'(DEPTH - 1);

  localparam logic [REG_WIDTH-1:0] CMD_WRITE = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] CMD_READ  = REG_WIDTH'(2);
`ifdef REG_CMD_MEM_FILL_EN
  localparam logic [REG_WIDTH-1:0] CMD_FILL  = REG_WIDTH'(3);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_READ_WB
`ifdef REG_CMD_MEM_FILL_EN
    ,
    S_FILL
`endif
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic                  r_dropped;
  logic                  r_prevCmdNz;
  logic [15:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_wrData;
  logic [DATA_WIDTH-1:0] r_rdData;
  logic [REG_WIDTH-1:0]  r_dataO;
`ifdef REG_CMD_MEM_FILL_EN
  logic [15:0]           r_cnt;
`endif

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic          w_cmdNz;
  logic          w_edge;
  logic          w_addrOk;
  logic          w_atTop;
  logic          w_memWe;
  logic [AW-1:0] w_idx;
  logic          w_unused;

  // A command edge is a non-NOP value whose previous-cycle value was NOP;
  // the captured address decides range errors and the last-word stop.
  always_comb begin
    w_cmdNz  = |bus.cmd_register;
    w_edge   = w_cmdNz && !r_prevCmdNz;
    w_addrOk = ({1'b0, r_addr} < DEPTH17);
    w_atTop  = ({1'b0, r_addr} == LAST17);
    w_idx    = r_addr[AW-1:0];
    w_memWe  = 1'b0;
    if (r_state == S_WRITE) begin
      w_memWe = w_addrOk;
    end
`ifdef REG_CMD_MEM_FILL_EN
    if (r_state == S_FILL) begin
      w_memWe = w_addrOk;
    end
`endif
  end

  // Register bits beyond the data and address fields carry no meaning here.
  assign w_unused = ^{bus.data_in_register, bus.address_register};

  assign bus.status_register = {{(REG_WIDTH-4){1'b0}}, r_dropped, r_error, r_done, r_busy};
  assign bus.data_o_register = r_dataO;

  // Memory array: no reset, one write port, read data registered every cycle.
  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[w_idx] <= r_wrData;
    end
    r_rdData <= r_mem[w_idx];
  end

  // Command FSM with registered status and read-data outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_dropped   <= 1'b0;
      r_prevCmdNz <= 1'b0;
      r_addr      <= '0;
      r_wrData    <= '0;
      r_dataO     <= '0;
`ifdef REG_CMD_MEM_FILL_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_prevCmdNz <= w_cmdNz;
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_dropped <= 1'b0;
            r_addr    <= bus.address_register[15:0];
            r_wrData  <= bus.data_in_register[DATA_WIDTH-1:0];
`ifdef REG_CMD_MEM_FILL_EN
            r_cnt     <= bus.address_register[31:16];
`endif
            if (bus.cmd_register == CMD_WRITE) begin
              r_state <= S_WRITE;
              r_busy  <= 1'b1;
            end else if (bus.cmd_register == CMD_READ) begin
              r_state <= S_READ;
              r_busy  <= 1'b1;
`ifdef REG_CMD_MEM_FILL_EN
            end else if (bus.cmd_register == CMD_FILL) begin
              r_state <= S_FILL;
              r_busy  <= 1'b1;
`endif
            end else begin
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (!w_addrOk) begin
            r_error <= 1'b1;
          end
        end
        S_READ: begin
          r_state <= S_READ_WB;
        end
        S_READ_WB: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (w_addrOk) begin
            r_dataO <= REG_WIDTH'(r_rdData);
          end else begin
            r_error <= 1'b1;
          end
        end
`ifdef REG_CMD_MEM_FILL_EN
        S_FILL: begin
          if (!w_addrOk) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_error <= 1'b1;
          end else if (r_cnt == 16'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_atTop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_error <= 1'b1;
          end else begin
            r_addr <= r_addr + 16'd1;
            r_cnt  <= r_cnt - 16'd1;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_edge && (r_state != S_IDLE)) begin
        r_dropped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_cmd_mem.sv
// tb_reg_cmd_mem: directed self-checking bench for reg_cmd_mem.
// dutA uses the default geometry (16-bit words, 1024 deep); dutB stores
// 32-bit words to show full-width storage.
module tb_reg_cmd_mem;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   testCnt = 0;
  int   failCnt = 0;

  reg_cmd_mem_if #(.REG_WIDTH(32)) busA ();
  reg_cmd_mem_if #(.REG_WIDTH(32)) busB ();

  reg_cmd_mem #(.REG_WIDTH(32), .DATA_WIDTH(16), .DEPTH(1024)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  reg_cmd_mem #(.REG_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Absolute time limit so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCnt++;
    assert (observed === expected) else begin
      failCnt++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One-cycle command pulse on dutA; returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic [31:0] cmd, input logic [31:0] addr,
                               input logic [31:0] data);
    @(negedge clk);
    busA.cmd_register     = cmd;
    busA.address_register = addr;
    busA.data_in_register = data;
    @(negedge clk);
    busA.cmd_register     = '0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busA.status_register[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " idle"}, {31'd0, busA.status_register[0]}, 32'd0);
  endtask

  task automatic readWord(input logic [31:0] addr, input logic [31:0] expected,
                          input string tag);
    applyStimulus(32'd2, addr, 32'd0);
    waitIdle(tag);
    checkOutput(tag, busA.data_o_register, expected);
  endtask

  initial begin
    int busyCnt;
    int guard;

    busA.cmd_register     = '0;
    busA.address_register = '0;
    busA.data_in_register = '0;
    busB.cmd_register     = '0;
    busB.address_register = '0;
    busB.data_in_register = '0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset status", busA.status_register, 32'h0);
    checkOutput("reset data_o", busA.data_o_register, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // WRITE 0x0000 with 0xDEADBEEF keeps only the low 16 bits
    applyStimulus(32'd1, 32'h0000_0000, 32'hDEAD_BEEF);
    checkOutput("write busy", busA.status_register, 32'h1);
    @(negedge clk);
    checkOutput("write done", busA.status_register, 32'h2);

    // READ 0x0000: data_o updates at the second edge after accept
    applyStimulus(32'd2, 32'h0000_0000, 32'h0);
    checkOutput("read busy", busA.status_register, 32'h1);
    @(negedge clk);
    checkOutput("read data early", busA.data_o_register, 32'h0);
    @(negedge clk);
    checkOutput("read data", busA.data_o_register, 32'h0000_BEEF);
    checkOutput("read status", busA.status_register, 32'h2);

    // Out-of-range WRITE then READ at DEPTH
    applyStimulus(32'd1, 32'h0000_0400, 32'h0000_5555);
    @(negedge clk);
    checkOutput("oob write status", busA.status_register, 32'h6);
    applyStimulus(32'd2, 32'h0000_0400, 32'h0);
    waitIdle("oob read");
    checkOutput("oob read status", busA.status_register, 32'h6);
    checkOutput("oob read data_o", busA.data_o_register, 32'h0000_BEEF);

    // WRITE held for 5 cycles executes once; later data must not be stored
    @(negedge clk);
    busA.cmd_register     = 32'd1;
    busA.address_register = 32'h0000_0010;
    busA.data_in_register = 32'h0000_1111;
    @(negedge clk);
    busA.data_in_register = 32'h0000_2222;
    repeat (4) @(negedge clk);
    busA.cmd_register     = '0;
    @(negedge clk);
    checkOutput("held write status", busA.status_register, 32'h2);
    readWord(32'h0000_0010, 32'h0000_1111, "held write data");

    // Illegal code: error and done right after accept, memory untouched
    applyStimulus(32'd7, 32'h0000_0010, 32'h0000_9999);
    checkOutput("illegal status", busA.status_register, 32'h6);
    readWord(32'h0000_0010, 32'h0000_1111, "illegal no write");
    checkOutput("status after clean read", busA.status_register, 32'h2);

    // New edge while a READ is busy is dropped and not executed
    applyStimulus(32'd2, 32'h0000_0000, 32'h0);
    @(negedge clk);
    busA.cmd_register     = 32'd1;
    busA.address_register = 32'h0000_0010;
    busA.data_in_register = 32'h0000_BBBB;
    @(negedge clk);
    checkOutput("dropped status", busA.status_register, 32'hA);
    checkOutput("dropped read data", busA.data_o_register, 32'h0000_BEEF);
    busA.cmd_register = '0;
    readWord(32'h0000_0010, 32'h0000_1111, "dropped no write");
    checkOutput("dropped cleared", busA.status_register, 32'h2);

`ifdef REG_CMD_MEM_FILL_EN
    // FILL from 0x3FC, count 5: stops after 0x3FF with error, busy 4 cycles
    applyStimulus(32'd3, 32'h0004_03FC, 32'h0000_1234);
    busyCnt = 0;
    guard   = 0;
    while (busA.status_register[0] && guard < 50) begin
      busyCnt++;
      @(negedge clk);
      guard++;
    end
    checkOutput("fill busy cycles", busyCnt, 32'd4);
    checkOutput("fill status", busA.status_register, 32'h6);
    readWord(32'h0000_03FC, 32'h0000_1234, "fill word 3FC");
    readWord(32'h0000_03FF, 32'h0000_1234, "fill word 3FF");

    // Edge during FILL is dropped; the fill keeps its captured address
    applyStimulus(32'd3, 32'h0003_0100, 32'h0000_AAAA);
    @(negedge clk);
    busA.cmd_register     = 32'd2;
    busA.address_register = 32'h0000_0000;
    @(negedge clk);
    busA.cmd_register     = '0;
    waitIdle("fill drop");
    checkOutput("fill drop status", busA.status_register, 32'hA);
    readWord(32'h0000_0100, 32'h0000_AAAA, "fill drop word 100");
    readWord(32'h0000_0103, 32'h0000_AAAA, "fill drop word 103");
    readWord(32'h0000_0000, 32'h0000_BEEF, "fill drop word 0");
`else
    // Without the FILL feature, code 3 is illegal
    applyStimulus(32'd3, 32'h0000_0010, 32'h0000_9999);
    checkOutput("code3 illegal status", busA.status_register, 32'h6);
    readWord(32'h0000_0010, 32'h0000_1111, "code3 no write");
`endif

    // Reset in the middle of a running command
`ifdef REG_CMD_MEM_FILL_EN
    applyStimulus(32'd3, 32'h0007_0200, 32'h0000_3333);
`else
    applyStimulus(32'd2, 32'h0000_0010, 32'h0);
`endif
    checkOutput("pre-reset busy", busA.status_register, 32'h1);
    #1 rst = 1'b0;
    #1;
    checkOutput("mid reset status", busA.status_register, 32'h0);
    checkOutput("mid reset data_o", busA.data_o_register, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    readWord(32'h0000_0000, 32'h0000_BEEF, "post reset read");
    checkOutput("post reset status", busA.status_register, 32'h2);

    // 32-bit word instance: WRITE 0x3FF then READ it back in full
    @(negedge clk);
    busB.cmd_register     = 32'd1;
    busB.address_register = 32'h0000_03FF;
    busB.data_in_register = 32'hCAFE_F00D;
    @(negedge clk);
    busB.cmd_register     = '0;
    @(negedge clk);
    checkOutput("wide write status", busB.status_register, 32'h2);
    busB.cmd_register     = 32'd2;
    @(negedge clk);
    busB.cmd_register     = '0;
    repeat (2) @(negedge clk);
    checkOutput("wide read data", busB.data_o_register, 32'hCAFE_F00D);
    checkOutput("wide read status", busB.status_register, 32'h2);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/reg_cmd_mem.md
REG_CMD_MEM -- requirements
Module: reg_cmd_mem

Interface
REQ-001 The block SHALL have parameter REG_WIDTH, default 32, meaning the width of every register port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning the stored word width, 1..REG_WIDTH.
REQ-003 The block SHALL have parameter DEPTH, default 1024, meaning the number of words, 2..65536.
REQ-004 The block SHALL have port clk  in  1  system clock; one clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port data_in_register  in  REG_WIDTH  write or fill value.
REQ-007 The block SHALL have port address_register  in  REG_WIDTH  bits [15:0] start address; bits [31:16] fill count minus 1.
REQ-008 The block SHALL have port cmd_register  in  REG_WIDTH  command: 0 NOP, 1 WRITE, 2 READ, 3 FILL; other values illegal.
REQ-009 The block SHALL have port status_register  out  REG_WIDTH  bit0 busy, bit1 done, bit2 error, bit3 dropped; other bits 0.
REQ-010 The block SHALL have port data_o_register  out  REG_WIDTH  last read word, zero-extended.

Function
REQ-011 A command SHALL be accepted only on a cycle where cmd_register is non-NOP, its previous-cycle value was NOP, and the FSM is IDLE.
REQ-012 A held non-NOP command SHALL execute once; re-issuing it requires an intervening NOP cycle.
REQ-013 A NOP-to-non-NOP edge arriving while busy SHALL be ignored and SHALL set dropped.
REQ-014 The FSM SHALL have states IDLE, WRITE, READ, READ_WB and FILL; IDLE is entered after every command.
REQ-015 On accept, done, error and dropped SHALL clear.
REQ-016 WRITE SHALL store data_in_register[DATA_WIDTH-1:0] at the address; the word is readable from the cycle after the WRITE state.
REQ-017 READ SHALL update data_o_register at the second rising edge after accept.
REQ-018 data_o_register SHALL hold its value until the next successful READ.
REQ-019 Any address >= DEPTH SHALL set error, write nothing, and leave data_o_register unchanged.
REQ-020 FILL SHALL write data_in_register[DATA_WIDTH-1:0] to count consecutive words, one per cycle, busy for count cycles.
REQ-021 A FILL that would pass address DEPTH-1 SHALL stop after writing DEPTH-1, SHALL NOT wrap, and SHALL set error.
REQ-022 Illegal command codes SHALL set error and done in the cycle after accept, with no memory access.
REQ-023 busy SHALL be 1 in every non-IDLE state.
REQ-024 done SHALL be set on return to IDLE and SHALL stay sticky until the next accept.
REQ-025 data_in_register and address_register SHALL be captured at accept; later input changes SHALL NOT affect a running command.

Reset
REQ-026 Asserting rst SHALL immediately force IDLE and clear status_register, data_o_register and the previous-command register to 0.
REQ-027 A command in progress when rst asserts SHALL be abandoned; memory contents are unspecified afterwards.
REQ-028 The memory array SHALL NOT be reset.
REQ-029 After rst deasserts, the first command SHALL be accepted only after a NOP-to-non-NOP edge.

Configuration
REQ-030 With macro REG_CMD_MEM_FILL_EN defined, FILL (code 3) SHALL behave as REQ-020 and REQ-021.
REQ-031 Without REG_CMD_MEM_FILL_EN, code 3 SHALL be illegal per REQ-022, and the FILL state and counter SHALL be absent.

Verification
REQ-032 Reset; WRITE 0x0000 with 0xDEADBEEF; NOP; READ 0x0000 -> data_o_register=0x0000BEEF at the second edge after accept, done=1, error=0.
REQ-033 Set DATA_WIDTH=32; WRITE 0x03FF with 0xCAFEF00D; READ 0x03FF -> 0xCAFEF00D.
REQ-034 WRITE address 0x0400 with DEPTH=1024 -> error=1, done=1; a following READ 0x0400 -> error=1, data_o_register unchanged.
REQ-035 With FILL_EN, FILL address 0x0004_03FC, data 0x1234 -> busy for 4 cycles, words 0x3FC..0x3FF read 0x1234, error=1.
REQ-036 Hold WRITE for 5 cycles -> one write only; a new edge while FILL is busy -> dropped=1 and the fill result is unchanged.
REQ-037 Assert rst mid-FILL -> status_register=0 and data_o_register=0 at once; after deassert a NOP-then-READ sequence works.
